// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t        : loader FSM states
//   WORD_W         : instruction word width
//   BYTE_W         : stream byte width
//   BYTES_PER_WORD : bytes packed into one instruction word
//   BCNT_W         : width of the byte-within-word counter
package imem_boot_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word packer.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-low reset
//   clear_i       : drop any partially assembled word
//   accept_i      : byte_i is taken this cycle
//   byte_i        : incoming stream byte
//   word_o        : word as it stands once byte_i is appended (valid with word_full_o)
//   word_full_o   : pulses on the accept that completes a word
module imem_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  // Only the first three bytes need storage; the fourth is appended
  // combinationally so the word is available on the accepting edge.
  logic [WORD_W-BYTE_W-1:0] r_shift;
  logic [BCNT_W-1:0]        r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (clear_i) begin
      r_cnt   <= '0;
    end else if (accept_i) begin
      r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], byte_i};
      r_cnt   <= r_cnt + BCNT_W'(1);
    end
  end

  assign word_o      = {r_shift, byte_i};
  assign word_full_o = accept_i && (r_cnt == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: packs a byte stream into 32-bit words,
// writes them to instruction memory while holding the CPU in reset, then
// releases the CPU for a programmed number of cycles and flags done.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-low reset
//   load_start_i   : start pulse, honoured in IDLE and DONE only
//   word_count_i   : words to load (clamped to 2^ADDR_W), latched on start
//   run_cycles_i   : CPU run length, latched on start
//   byte_*         : byte stream handshake
//   mem_*          : instruction-memory write port (byte address, word aligned)
//   cpu_rst_o      : CPU reset, active-low
//   done_o         : run finished, CPU state stable
//   dbg_state_o    : current FSM state
//
// Handshake: a byte transfers on a rising edge where byte_valid_i and
// byte_ready_o are both 1. The source must hold byte_data_i stable with
// byte_valid_i high until that edge; ready is high only in LOAD.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_start_i,
  input  logic [ADDR_W:0]   word_count_i,
  input  logic [CNT_W-1:0]  run_cycles_i,
  input  logic [BYTE_W-1:0] byte_data_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [WORD_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic [2:0]        dbg_state_o
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W:0]     r_count;
  logic [CNT_W-1:0]    r_run;
  logic [ADDR_W-1:0]   r_idx;
  logic [CNT_W-1:0]    r_run_cnt;
  logic                r_ready;
  logic                r_we;
  logic                r_cpu_rst;
  logic                r_done;
  logic [WORD_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;

  logic                w_start;
  logic [ADDR_W:0]     w_count_clamped;
  logic                w_accept;
  logic [WORD_W-1:0]   w_word;
  logic                w_word_full;
  logic                w_last_word;
  logic                w_run_last;

  assign w_start         = load_start_i && ((r_state == IDLE) || (r_state == DONE));
  assign w_count_clamped = (word_count_i > MAX_WORDS) ? MAX_WORDS : word_count_i;
  assign w_accept        = byte_valid_i && r_ready;
  assign w_last_word     = ({1'b0, r_idx} == (r_count - (ADDR_W+1)'(1)));
  assign w_run_last      = (r_run_cnt == (r_run - CNT_W'(1)));

  imem_word_packer u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (w_start),
    .accept_i    (w_accept),
    .byte_i      (byte_data_i),
    .word_o      (w_word),
    .word_full_o (w_word_full)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_start) begin
          if (w_count_clamped == '0) w_next = (run_cycles_i == '0) ? DONE : RUN;
          else                       w_next = LOAD;
        end
      end
      LOAD:    if (w_word_full) w_next = WRITE;
      WRITE: begin
        if (w_last_word) w_next = (r_run == '0) ? DONE : RUN;
        else             w_next = LOAD;
      end
      RUN:     if (w_run_last) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count   <= '0;
      r_run     <= '0;
      r_idx     <= '0;
      r_run_cnt <= '0;
      r_ready   <= 1'b0;
      r_we      <= 1'b0;
      r_cpu_rst <= 1'b0;
      r_done    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_ready   <= (w_next == LOAD);
      r_we      <= (w_next == WRITE);
      r_cpu_rst <= (w_next == RUN) || (w_next == DONE);
      r_done    <= (w_next == DONE);

      if (w_start) begin
        r_count <= w_count_clamped;
        r_run   <= run_cycles_i;
        r_idx   <= '0;
      end else if ((r_state == WRITE) && (w_next == LOAD)) begin
        r_idx   <= r_idx + ADDR_W'(1);
      end

      // Capture on the completing accept so the write shows one cycle later.
      if (w_word_full) begin
        r_addr  <= {{(WORD_W-ADDR_W-2){1'b0}}, r_idx, 2'b00};
        r_wdata <= w_word;
      end

      if (r_state == RUN) r_run_cnt <= r_run_cnt + CNT_W'(1);
      else                r_run_cnt <= '0;
    end
  end

  assign byte_ready_o = r_ready;
  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign cpu_rst_o    = r_cpu_rst;
  assign done_o       = r_done;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              load_start_i = 1'b0;
  logic [ADDR_W:0]   word_count_i = '0;
  logic [CNT_W-1:0]  run_cycles_i = '0;
  logic [7:0]        byte_data_i = '0;
  logic              byte_valid_i = 1'b0;
  logic              byte_ready_o;
  logic              mem_we_o;
  logic [31:0]       mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              cpu_rst_o;
  logic              done_o;
  logic [2:0]        dbg_state_o;

  imem_boot_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_start_i (load_start_i),
    .word_count_i (word_count_i),
    .run_cycles_i (run_cycles_i),
    .byte_data_i  (byte_data_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .cpu_rst_o    (cpu_rst_o),
    .done_o       (done_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];      // {addr, data}
  int          exp_cyc_q[$];  // cycle in which the write must be visible
  int          run_q[$];      // expected CPU run length per load
  logic [31:0] tb_mem [0:31];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // ---------------- monitor ----------------
  int   run_cnt   = 0;
  logic prev_done = 1'b0;

  always @(negedge clk_i) begin
    if (mem_we_o) begin
      tb_mem[mem_addr_o[6:2]] = mem_wdata_o;
      check("ready_low_in_write", 64'(byte_ready_o), 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %08h data %08h with nothing expected",
                 mem_addr_o, mem_wdata_o);
      end else begin
        check("write_addr_data", {mem_addr_o, mem_wdata_o}, exp_q.pop_front());
        check("write_latency_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end
    if (done_o && !prev_done) begin
      if (run_q.size() == 0) fail_now("unexpected_done");
      else check("run_cycles", 64'(run_cnt), 64'(run_q.pop_front()));
    end
    if (!rst_i || !cpu_rst_o || done_o) run_cnt = 0;
    else                                run_cnt++;
    prev_done = done_o;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start(input logic [ADDR_W:0] wc, input logic [CNT_W-1:0] rc);
    load_start_i = 1'b1;
    word_count_i = wc;
    run_cycles_i = rc;
    run_q.push_back(int'(rc));
    tick();
    load_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max, output bit ok);
    int   gap;
    logic rdy;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (gap) begin
      byte_valid_i = 1'b0;
      byte_data_i  = 8'($urandom);
      tick();
    end
    byte_data_i  = b;
    byte_valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      rdy = byte_ready_o;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) $display("FAIL byte_accept_timeout: byte %02h not taken in 50 cycles", b);
    if (!ok) begin
      n_checks++;
      n_fail++;
    end
  endtask

  task automatic send_word(input int idx, input logic [31:0] w, input int gap_max);
    bit ok;
    bit all_ok;
    logic [31:0] tmp;
    all_ok = 1'b1;
    tmp = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(tmp[31:24], gap_max, ok);
      tmp = tmp << 8;
      all_ok = all_ok & ok;
    end
    if (all_ok) begin
      exp_q.push_back({32'(idx) << 2, w});
      exp_cyc_q.push_back(cyc);
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("done_timeout");
    tick();
  endtask

  // ---------------- stimulus ----------------
  bit ok_b;

  initial begin
    for (int i = 0; i < 32; i++) tb_mem[i] = 32'hxxxxxxxx;

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_flags", 64'({byte_ready_o, mem_we_o, cpu_rst_o, done_o}), 64'd0);
    check("reset_addr_data", {mem_addr_o, mem_wdata_o}, 64'd0);
    check("reset_state", 64'(dbg_state_o), 64'd0);
    rst_i = 1'b1;
    tick();

    // Basic two-word load, valid held high, run for 5 cycles
    start(6'd2, 16'd5);
    send_word(0, 32'h20080003, 0);
    send_word(1, 32'h00000000, 0);
    byte_valid_i = 1'b0;
    wait_done(100);

    // Restart from DONE: both flags drop on the next edge; 3-word load under backpressure
    start(6'd3, 16'd4);
    check("restart_done_low", 64'(done_o), 64'd0);
    check("restart_cpu_rst_low", 64'(cpu_rst_o), 64'd0);
    send_word(0, 32'hDEADBEEF, 3);
    send_word(1, 32'h01234567, 3);
    send_word(2, 32'hA5C30F96, 3);
    byte_valid_i = 1'b0;
    wait_done(100);
    check("mem2_after_bp", 64'(tb_mem[2]), 64'h00000000A5C30F96);

    // Zero words, run 3
    start(6'd0, 16'd3);
    wait_done(50);

    // Clamp: 40 requested, 32 written, last at 0x7C
    start(6'd40, 16'd2);
    for (int i = 0; i < 32; i++) send_word(i, 32'h10000000 + 32'(i) * 32'h00010203, 0);
    byte_valid_i = 1'b0;
    wait_done(100);
    check("mem31_after_clamp", 64'(tb_mem[31]), 64'(32'h10000000 + 32'd31 * 32'h00010203));

    // Reset in the middle of word 1
    start(6'd2, 16'd1);
    send_word(0, 32'hCAFEF00D, 0);
    send_byte(8'h12, 0, ok_b);
    send_byte(8'h34, 0, ok_b);
    byte_valid_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    check("midload_rst_flags", 64'({byte_ready_o, mem_we_o, cpu_rst_o, done_o}), 64'd0);
    check("midload_rst_addr_data", {mem_addr_o, mem_wdata_o}, 64'd0);
    check("midload_word0_kept", 64'(tb_mem[0]), 64'h00000000CAFEF00D);
    run_q.delete();
    tick();
    rst_i = 1'b1;
    tick();
    start(6'd2, 16'd1);
    send_word(0, 32'hCAFEF00D, 0);
    send_word(1, 32'h12345678, 0);
    byte_valid_i = 1'b0;
    wait_done(100);
    check("word1_rewritten", 64'(tb_mem[1]), 64'h0000000012345678);

    // From IDLE: zero words and zero run go straight to DONE
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    start(6'd0, 16'd0);
    check("zero_zero_done", 64'(done_o), 64'd1);
    check("zero_zero_cpu_rst", 64'(cpu_rst_o), 64'd1);
    wait_done(10);

    repeat (2) tick();
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("run_q_drained", 64'(run_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
